// File: rtl/rx_reset_sequencer_pkg.sv
// ============================================================================
// Module   : rx_reset_sequencer_pkg
// Purpose  : Shared types and state codes for the rx reset sequencer.
//            Holds the sequencer FSM encodings next to the rx state codes so
//            every rx block agrees on them.
// Contents : c_RST_ST_* state codes, rst_state_e FSM enum, default widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_reset_sequencer_pkg;

  // Default widths of the length inputs / down-counter and the event counter
  localparam int RX_RST_SEQ_CNT_WIDTH_DEF     = 8;
  localparam int RX_RST_SEQ_EVT_CNT_WIDTH_DEF = 16;

  // Sequencer FSM state codes
  localparam logic [1:0] c_RST_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_RST_ST_ASSERT  = 2'd1;
  localparam logic [1:0] c_RST_ST_HOLDOFF = 2'd2;

  typedef enum logic [1:0] {
    RST_IDLE    = c_RST_ST_IDLE,
    RST_ASSERT  = c_RST_ST_ASSERT,
    RST_HOLDOFF = c_RST_ST_HOLDOFF
  } rst_state_e;

endpackage : rx_reset_sequencer_pkg

`default_nettype wire

// File: rtl/rx_reset_sequencer_if.sv
// ============================================================================
// Module   : rx_reset_sequencer_if
// Purpose  : Control/status bundle between the reset requester side and the
//            rx reset sequencer.
// Signals  : enable, receiver_rst, rst_len, holdoff_len, clear_count (to the
//            sequencer); core_rstn, rst_busy, rst_event, rst_event_count
//            (from the sequencer).
// Modports : master - requester / controller side
//            slave  - rx_reset_sequencer side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_reset_sequencer_if #(
  parameter int CNT_WIDTH     = 8,
  parameter int EVT_CNT_WIDTH = 16
) ();

  logic                     enable;
  logic                     receiver_rst;
  logic [CNT_WIDTH-1:0]     rst_len;
  logic [CNT_WIDTH-1:0]     holdoff_len;
  logic                     clear_count;
  logic                     core_rstn;
  logic                     rst_busy;
  logic                     rst_event;
  logic [EVT_CNT_WIDTH-1:0] rst_event_count;

  modport master (
    output enable,
    output receiver_rst,
    output rst_len,
    output holdoff_len,
    output clear_count,
    input  core_rstn,
    input  rst_busy,
    input  rst_event,
    input  rst_event_count
  );

  modport slave (
    input  enable,
    input  receiver_rst,
    input  rst_len,
    input  holdoff_len,
    input  clear_count,
    output core_rstn,
    output rst_busy,
    output rst_event,
    output rst_event_count
  );

endinterface : rx_reset_sequencer_if

`default_nettype wire

// File: rtl/rx_rst_event_counter.sv
// ============================================================================
// Module   : rx_rst_event_counter
// Purpose  : Saturating event counter with synchronous clear. Clear has
//            priority over a simultaneous increment.
// Ports    : clk     - clock
//            rstn    - asynchronous active-low reset
//            i_inc   - count one event
//            i_clr   - synchronous clear to zero
//            o_count - current count, sticks at all-ones
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_rst_event_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic      [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_count = r_count;

endmodule : rx_rst_event_counter

`default_nettype wire

// File: rtl/rx_reset_sequencer.sv
// ============================================================================
// Module   : rx_reset_sequencer
// Purpose  : Turns the signal_watchdog receiver_rst request into a clean,
//            fixed-length active-low reset for the rx pipeline, followed by
//            a hold-off window during which new requests are dropped.
// Ports    : clk  - clock, all logic on posedge
//            rstn - asynchronous active-low reset
//            bus  - rx_reset_sequencer_if.slave:
//                   enable, receiver_rst, rst_len, holdoff_len, clear_count
//                   core_rstn, rst_busy, rst_event, rst_event_count
// Config   : `define RX_RST_SEQ_EVENT_COUNTER_EN enables the saturating
//            accepted-request counter; otherwise rst_event_count reads 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_reset_sequencer
  import rx_reset_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH     = RX_RST_SEQ_CNT_WIDTH_DEF,
  parameter int EVT_CNT_WIDTH = RX_RST_SEQ_EVT_CNT_WIDTH_DEF
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  rx_reset_sequencer_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  rst_state_e           r_state;
  rst_state_e           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_hold_len;      // hold-off length captured at trigger
  logic [CNT_WIDTH-1:0] w_hold_len_nxt;
  logic [CNT_WIDTH-1:0] w_len_m1;        // max(rst_len,1)-1
  logic                 w_accept;
  logic                 r_core_rstn;
  logic                 r_busy;
  logic                 r_event;

  assign w_len_m1 = (bus.rst_len == '0) ? '0 : (bus.rst_len - c_ONE);

  // --------------------------------------------------------------------------
  // Next-state / counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hold_len_nxt = r_hold_len;
    w_accept       = 1'b0;

    if (!bus.enable) begin
      // Abort: straight back to idle, no hold-off
      w_state_nxt = RST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        RST_IDLE: begin
          if (bus.receiver_rst) begin
            w_accept       = 1'b1;
            w_state_nxt    = RST_ASSERT;
            w_cnt_nxt      = w_len_m1;
            w_hold_len_nxt = bus.holdoff_len;
          end
        end

        RST_ASSERT: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - c_ONE;
          end else if (r_hold_len == '0) begin
            w_state_nxt = RST_IDLE;
          end else begin
            w_state_nxt = RST_HOLDOFF;
            w_cnt_nxt   = r_hold_len - c_ONE;
          end
        end

        RST_HOLDOFF: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - c_ONE;
          end else if (bus.receiver_rst) begin
            // The closing edge of the last blanking cycle already lies at
            // trigger + rst_len + holdoff_len, so a request there is taken.
            w_accept       = 1'b1;
            w_state_nxt    = RST_ASSERT;
            w_cnt_nxt      = w_len_m1;
            w_hold_len_nxt = bus.holdoff_len;
          end else begin
            w_state_nxt = RST_IDLE;
          end
        end

        default: begin
          w_state_nxt = RST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs (outputs follow the next state so they are
  // aligned with the state they describe)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RST_IDLE;
      r_cnt       <= '0;
      r_hold_len  <= '0;
      r_core_rstn <= 1'b1;
      r_busy      <= 1'b0;
      r_event     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_len  <= w_hold_len_nxt;
      r_core_rstn <= (w_state_nxt != RST_ASSERT);
      r_busy      <= (w_state_nxt != RST_IDLE);
      r_event     <= w_accept;
    end
  end

  assign bus.core_rstn = r_core_rstn;
  assign bus.rst_busy  = r_busy;
  assign bus.rst_event = r_event;

  // --------------------------------------------------------------------------
  // Optional accepted-request counter
  // --------------------------------------------------------------------------
`ifdef RX_RST_SEQ_EVENT_COUNTER_EN
  rx_rst_event_counter #(
    .WIDTH   (EVT_CNT_WIDTH)
  ) u_evt_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (w_accept),
    .i_clr   (bus.clear_count),
    .o_count (bus.rst_event_count)
  );
`else
  logic w_unused_clear;
  assign w_unused_clear      = bus.clear_count;
  assign bus.rst_event_count = '0;
`endif

endmodule : rx_reset_sequencer

`default_nettype wire

// File: tb/tb_rx_reset_sequencer.sv
// ============================================================================
// Module   : tb_rx_reset_sequencer
// Purpose  : Self-checking bench for rx_reset_sequencer. A reference model
//            tracks each accepted trigger as (start edge, length, hold-off)
//            and derives the expected outputs from edge arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_reset_sequencer;

  localparam int CW = 8;
  localparam int EW = 4;   // narrow event counter so saturation is reachable
  localparam int EVT_MAX = (1 << EW) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  rx_reset_sequencer_if #(.CNT_WIDTH(CW), .EVT_CNT_WIDTH(EW)) bus ();

  rx_reset_sequencer #(
    .CNT_WIDTH     (CW),
    .EVT_CNT_WIDTH (EW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int e       = 0;  // index of the most recent posedge
  bit m_run   = 0;  // a sequence has been accepted and not aborted
  int m_start = 0;  // edge at which it was accepted
  int m_L     = 1;  // max(rst_len,1)
  int m_H     = 0;  // holdoff_len
  bit exp_rstn = 1'b1;
  bit exp_busy = 1'b0;
  bit exp_evt  = 1'b0;
  int exp_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run    = 0;
    exp_rstn = 1'b1;
    exp_busy = 1'b0;
    exp_evt  = 1'b0;
    exp_cnt  = 0;
  endtask

  // Called right after each posedge with the inputs that were sampled there
  task automatic model_edge();
    bit acc;
    int gap;
    e++;
    acc = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!bus.enable) begin
      m_run = 0;
    end else if (bus.receiver_rst) begin
      gap = m_L + ((m_H > 0) ? m_H : 1);
      if (!m_run || (e >= m_start + gap)) begin
        acc     = 1;
        m_run   = 1;
        m_start = e;
        m_L     = (bus.rst_len == 0) ? 1 : int'(bus.rst_len);
        m_H     = int'(bus.holdoff_len);
      end
    end
    exp_evt  = acc;
    exp_rstn = !(m_run && (e < m_start + m_L));
    exp_busy = m_run && (e < m_start + m_L + m_H);
`ifdef RX_RST_SEQ_EVENT_COUNTER_EN
    if (bus.clear_count)                 exp_cnt = 0;
    else if (acc && (exp_cnt < EVT_MAX)) exp_cnt = exp_cnt + 1;
`else
    exp_cnt = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("core_rstn", {31'd0, bus.core_rstn}, {31'd0, exp_rstn});
    check_val("rst_busy",  {31'd0, bus.rst_busy},  {31'd0, exp_busy});
    check_val("rst_event", {31'd0, bus.rst_event}, {31'd0, exp_evt});
    check_val("evt_count", 32'(bus.rst_event_count), exp_cnt);
    @(negedge clk);
  endtask

  task automatic drive(input bit en, input bit rr, input int rl, input int hl, input bit clr);
    bus.enable       = en;
    bus.receiver_rst = rr;
    bus.rst_len      = CW'(rl);
    bus.holdoff_len  = CW'(hl);
    bus.clear_count  = clr;
  endtask

  initial begin
    drive(1, 0, 4, 3, 0);
    #1 rstn = 1'b0;
    #1;
    check_val("rst_core_rstn", {31'd0, bus.core_rstn}, 1);
    check_val("rst_busy0",     {31'd0, bus.rst_busy},  0);
    check_val("rst_event0",    {31'd0, bus.rst_event}, 0);
    check_val("rst_count0",    32'(bus.rst_event_count), 0);
    @(negedge clk);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // rst_len=4, holdoff=3: single pulse, ignored retry at +6, accepted at +7
    drive(1, 1, 4, 3, 0);
    tick();
    check_val("t2_evt", {31'd0, bus.rst_event}, 1);
    drive(1, 0, 4, 3, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) check_val("t2_rstn_last_lo", {31'd0, bus.core_rstn}, 0);
      if (i == 4) check_val("t2_rstn_rel",     {31'd0, bus.core_rstn}, 1);
      if (i == 4) check_val("t2_busy_hold",    {31'd0, bus.rst_busy},  1);
    end
    drive(1, 1, 4, 3, 0);
    tick();
    check_val("t2_ignored", {31'd0, bus.rst_event}, 0);
    tick();
    check_val("t2_accepted", {31'd0, bus.rst_event}, 1);
    check_val("t2_acc_rstn", {31'd0, bus.core_rstn}, 0);
    drive(1, 0, 4, 3, 0);
    for (int i = 0; i < 10; i++) tick();

    // Abort by enable 3 cycles into an 8-cycle assertion
    drive(1, 1, 8, 3, 0);
    tick();
    drive(1, 0, 8, 3, 0);
    for (int i = 0; i < 3; i++) tick();
    drive(0, 0, 8, 3, 0);
    tick();
    check_val("t4_rstn", {31'd0, bus.core_rstn}, 1);
    check_val("t4_busy", {31'd0, bus.rst_busy},  0);
    drive(1, 0, 8, 3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t4_no_hold", {31'd0, bus.rst_busy}, 0);
    end

    // Level-high request, zero lengths: low 1 cycle out of every 2
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_val("t3_rstn", {31'd0, bus.core_rstn}, (i % 2 == 0) ? 0 : 1);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    tick();

    // Clear coincident with a trigger
    drive(1, 1, 2, 1, 1);
    tick();
    check_val("t5_clr_evt", {31'd0, bus.rst_event}, 1);
    check_val("t5_clr_cnt", 32'(bus.rst_event_count), 0);
    drive(1, 0, 2, 1, 0);
    for (int i = 0; i < 5; i++) tick();

    // Async reset in the middle of an assertion
    drive(1, 1, 6, 2, 0);
    tick();
    drive(1, 0, 6, 2, 0);
    tick();
    rstn = 1'b0;
    #1;
    model_reset();
    check_val("t1_rstn_async", {31'd0, bus.core_rstn}, 1);
    check_val("t1_busy_async", {31'd0, bus.rst_busy},  0);
    check_val("t1_cnt_async",  32'(bus.rst_event_count), 0);
    @(negedge clk);
    tick();
    rstn = 1'b1;
    drive(1, 1, 6, 2, 0);
    tick();
    check_val("t1_retrigger", {31'd0, bus.rst_event}, 1);
    drive(1, 0, 6, 2, 0);
    for (int i = 0; i < 10; i++) tick();

    // Randomised traffic, including length changes mid-sequence
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 19) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 6),
            $urandom_range(0, 5),
            $urandom_range(0, 39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rx_reset_sequencer

`default_nettype wire
